tape_mem: RTL and testbench
===========================

# tape_mem

Shared data-tape memory that sits directly downstream of the last core's select stage. It terminates the daisy-chained load/store request lines and returns load data with the fixed two-cycle latency the select stages expect. It also zero-fills the tape after reset so every cell starts at 0.

## Interface

Parameters:

- `ADDR_W`, 16: tape depth is 2^ADDR_W words of 16 bits. Address bits above `ADDR_W-1` are ignored.

Ports:

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ld_en`, in, 1: load request for this cycle, the end of the select-stage chain.
- `ld_addr`, in, 16: load address, sampled when `ld_en` = 1.
- `st_en`, in, 1: store request for this cycle.
- `st_addr`, in, 16: store address, sampled when `st_en` = 1.
- `st_data`, in, 16: store data, sampled when `st_en` = 1.
- `ld_data`, out, 16: load result, valid exactly two cycles after the `ld_en` cycle.
- `ld_vld`, out, 1: high in the cycle `ld_data` carries a result (debug/verification only).
- `busy`, out, 1: clear sweep in progress. Top level holds every core's `core_en` low while this is 1.

## Operation

- No backpressure: every `ld_en` and every `st_en` is accepted in the cycle it is asserted.
- `ld_en` and `st_en` may be high in the same cycle, with the same or different addresses.
- FSM states:
  - CLEAR: entered on reset. A counter `clr_addr` runs 0 .. 2^ADDR_W-1 and writes 0 to one word per cycle. `busy` = 1. `ld_en`/`st_en` are ignored, and `ld_vld` stays 0.
  - READY: entered after the last word is written. `busy` = 0. The FSM stays here until the next reset.
- Store, READY state: `mem[st_addr[ADDR_W-1:0]] <= st_data` at the edge ending the `st_en` cycle.
- Load ordering rule: the result reflects every store accepted in cycles up to and including the load cycle. It reflects no store accepted afterwards.
- Same-cycle store and load to the same address: the load returns `st_data` (write-first bypass in the issue cycle).
- A store in the cycle after the load, to the same address, must NOT alter the result. The read is captured in stage 1.
- Pipeline:
  - Stage 1 registers the read word (bypassed as above) and a valid bit.
  - Stage 2 registers `ld_data`/`ld_vld`.
  - Back-to-back loads in consecutive cycles each return in order, one per cycle.
- `ld_data` holds its last value when `ld_vld` = 0.
- Addresses wrap modulo 2^ADDR_W. With `ADDR_W` < 16, 16'h0000 and 16'h(2^ADDR_W) alias the same word.

## Timing

- Reset values: `ld_data` = 16'h0000, `ld_vld` = 0, `busy` = 1, FSM = CLEAR, `clr_addr` = 0, stage-1 valid = 0.
- `ld_en` high in cycle t gives `ld_vld` = 1 and `ld_data` = result in cycle t+2. This latency is fixed.
- `busy` falls in the cycle after the final clear write. The sweep therefore keeps `busy` high for 2^ADDR_W cycles after `rst_n` deasserts.
- Reset asserted mid-operation:
  - In-flight loads are discarded; `ld_vld` goes to 0 immediately (asynchronous).
  - The FSM returns to CLEAR and the sweep restarts from address 0.
- Store path latency: a word written at edge e is readable by a load issued in the cycle after e. Same-cycle reads are covered by the bypass.

## Configuration

- `TAPE_MEM_CLEAR_EN` defined: CLEAR sweep as described above.
- `TAPE_MEM_CLEAR_EN` undefined:
  - No sweep logic. The FSM goes to READY in the first cycle after `rst_n` deasserts, and `busy` is 1 only during reset.
  - Tape contents come from memory preinitialisation and are not cleared by reset.
  - Load/store behaviour is otherwise identical.

## Test plan

- Clear sweep (`ADDR_W`=4, clear enabled): release reset, then `busy` is high 16 cycles. After that, loads of addresses 0..15 each return 16'h0000 at t+2 with `ld_vld`=1.
- Store then load: store 16'h1234 to addr 5 at cycle t, load addr 5 at t+1. Expect `ld_data`=16'h1234 at t+3.
- Same-cycle bypass: word 7 = 16'h0001. Store 16'h00FF and load to addr 7 in the same cycle t. Expect 16'h00FF at t+2.
- Late store ignored: word 3 = 16'h0010. Load addr 3 at t, store 16'hBEEF to addr 3 at t+1. Expect 16'h0010 at t+2, and a later load of addr 3 returns 16'hBEEF.
- Back-to-back plus wrap (`ADDR_W`=4): store 16'hA to addr 2. Load 16'h0012 at t and 16'h0002 at t+1. Expect 16'hA at t+2 and t+3, with `ld_vld` high both cycles.
- Reset mid-operation: pulse `rst_n` low while a load is in flight. `ld_vld` must never assert for that load, `busy` returns to 1, and the sweep restarts at address 0.

Source files
------------

// File: rtl/tape_mem_if.sv
// tape_mem_if: load/store bus between the last select stage and the shared tape memory.
//
// Signals (all 16-bit data/address, single-bit strobes):
//   ld_en, ld_addr           load request from the end of the select-stage chain
//   st_en, st_addr, st_data  store request
//   ld_data, ld_vld          load result, two cycles after ld_en
//   busy                     clear sweep in progress; cores must stay disabled
//
// Modports: master = request side (select stage / testbench), slave = tape memory.

interface tape_mem_if;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic        st_en;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic [15:0] ld_data;
    logic        ld_vld;
    logic        busy;

    modport master (
        output ld_en,
        output ld_addr,
        output st_en,
        output st_addr,
        output st_data,
        input  ld_data,
        input  ld_vld,
        input  busy
    );

    modport slave (
        input  ld_en,
        input  ld_addr,
        input  st_en,
        input  st_addr,
        input  st_data,
        output ld_data,
        output ld_vld,
        output busy
    );
endinterface

// File: rtl/tape_mem.sv
// tape_mem: shared 16-bit data tape terminating the daisy-chained load/store lines.
//
// Loads return with a fixed two-cycle latency (stage 1 captures the read word, stage 2
// drives ld_data/ld_vld). A store in the same cycle as a load to the same word is bypassed
// into the load result; stores in later cycles never affect an already-issued load.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of tape_mem_if (ld_*/st_* requests, ld_data/ld_vld/busy)
//
// Parameters:
//   ADDR_W  tape depth is 2**ADDR_W words; address bits above ADDR_W-1 are ignored.
//
// Build option:
//   TAPE_MEM_CLEAR_EN  defined: after reset a sweep writes 0 to every word, one per cycle,
//                      with busy held high. Undefined: no sweep, READY one cycle after
//                      reset release, tape contents survive reset.

module tape_mem #(
    parameter int unsigned ADDR_W = 16
) (
    input logic       clk,
    input logic       rst_n,
    tape_mem_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    logic [15:0] r_mem [DEPTH];

    state_e r_state;
    state_e w_state_nxt;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [15:0]       w_wr_data;

    logic [ADDR_W-1:0] w_ld_idx;
    logic [ADDR_W-1:0] w_st_idx;
    logic              w_ready;
    logic              w_ld_acc;
    logic              w_st_acc;
    logic [15:0]       w_rd_word;

    logic [15:0] r_s1_data;
    logic        r_s1_vld;
    logic [15:0] r_ld_data;
    logic        r_ld_vld;

    // Upper address bits alias onto the same word.
    assign w_ld_idx = bus.ld_addr[ADDR_W-1:0];
    assign w_st_idx = bus.st_addr[ADDR_W-1:0];

    assign w_ready  = (r_state == StReady);
    assign w_ld_acc = bus.ld_en & w_ready;
    assign w_st_acc = bus.st_en & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StClear;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef TAPE_MEM_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr <= '0;
        end else begin
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_wr_en        = 1'b0;
        w_wr_addr      = w_st_idx;
        w_wr_data      = bus.st_data;
        unique case (r_state)
            StClear: begin
                // The sweep owns the single write port; requests are ignored meanwhile.
                w_wr_en        = 1'b1;
                w_wr_addr      = r_clr_addr;
                w_wr_data      = 16'h0000;
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == {ADDR_W{1'b1}}) begin
                    w_state_nxt = StReady;
                end
            end
            StReady: begin
                w_wr_en = w_st_acc;
            end
            default: begin
                w_state_nxt = StClear;
            end
        endcase
    end
`else
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_addr   = w_st_idx;
        w_wr_data   = bus.st_data;
        unique case (r_state)
            StClear: begin
                w_state_nxt = StReady;
            end
            StReady: begin
                w_wr_en = w_st_acc;
            end
            default: begin
                w_state_nxt = StClear;
            end
        endcase
    end
`endif

    // Tape storage has no reset; only the sweep (if built) initialises it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Write-first bypass: a same-cycle store to the loaded word wins over the array.
    always_comb begin
        w_rd_word = r_mem[w_ld_idx];
        if (w_st_acc && (w_st_idx == w_ld_idx)) begin
            w_rd_word = bus.st_data;
        end
    end

    // Stage 1 captures the word at the end of the load cycle, so later stores cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data <= 16'h0000;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_vld <= w_ld_acc;
            if (w_ld_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    // Stage 2: ld_data holds its last result while ld_vld is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_data <= 16'h0000;
            r_ld_vld  <= 1'b0;
        end else begin
            r_ld_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_ld_data <= r_s1_data;
            end
        end
    end

    assign bus.ld_data = r_ld_data;
    assign bus.ld_vld  = r_ld_vld;
    assign bus.busy    = (r_state == StClear);

    generate
        if (ADDR_W < 16) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^{bus.ld_addr[15:ADDR_W], bus.st_addr[15:ADDR_W]};
        end
    endgenerate

endmodule

// File: tb/tb_tape_mem.sv
// tb_tape_mem: directed self-checking bench for tape_mem with ADDR_W = 4.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same
// point, so "cycle t+2" is two tick() calls after the load was driven.
// Clear-sweep checks apply when TAPE_MEM_CLEAR_EN is defined; otherwise the bench checks
// the no-sweep behaviour and writes every word it reads first.

module tb_tape_mem;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    tape_mem_if bus ();

    tape_mem #(
        .ADDR_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_en   = 1'b0;
        bus.ld_addr = 16'h0000;
        bus.st_en   = 1'b0;
        bus.st_addr = 16'h0000;
        bus.st_data = 16'h0000;
    endtask

    // Stimulus only: one store cycle, returns in the following cycle.
    task automatic drive_store(input logic [15:0] addr, input logic [15:0] data);
        bus.st_en   = 1'b1;
        bus.st_addr = addr;
        bus.st_data = data;
        tick();
        bus.st_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus.ld_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ld_vld: got %b expected 0", bus.ld_vld);
        end
        n_checks++;
        if (bus.ld_data !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_ld_data: got %h expected 0000", bus.ld_data);
        end
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_busy: got %b expected 1", bus.busy);
        end
    endtask

    // Releases reset and checks the busy window that follows.
    task automatic release_and_check_busy(input string tag);
        int n;
        rst_n = 1'b1;
`ifdef TAPE_MEM_CLEAR_EN
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        n_checks++;
        if (n != 16) begin
            n_errors++;
            $display("FAIL %s_busy_cycles: got %0d expected 16", tag, n);
        end
`else
        n = 0;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_busy_after_release: got %b expected 0", tag, bus.busy);
        end
`endif
    endtask

    task automatic test_clear();
        release_and_check_busy("clear");
`ifdef TAPE_MEM_CLEAR_EN
        // Loads 0..15 back to back; each cycle checks the load issued two cycles earlier.
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                bus.ld_en   = 1'b1;
                bus.ld_addr = 16'(i);
            end else begin
                bus.ld_en = 1'b0;
            end
            if (i >= 2) begin
                n_checks++;
                if (bus.ld_vld !== 1'b1 || bus.ld_data !== 16'h0000) begin
                    n_errors++;
                    $display("FAIL clear_word_%0d: got vld=%b data=%h expected vld=1 data=0000",
                             i - 2, bus.ld_vld, bus.ld_data);
                end
            end
            tick();
        end
        bus.ld_en = 1'b0;
`endif
    endtask

    task automatic test_store_load();
        drive_store(16'h0005, 16'h1234);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 16'h0005;
        tick();
        bus.ld_en = 1'b0;
        tick();
        n_checks++;
        if (bus.ld_vld !== 1'b1) begin
            n_errors++;
            $display("FAIL store_load_vld: got %b expected 1", bus.ld_vld);
        end
        n_checks++;
        if (bus.ld_data !== 16'h1234) begin
            n_errors++;
            $display("FAIL store_load_data: got %h expected 1234", bus.ld_data);
        end
    endtask

    task automatic test_bypass();
        drive_store(16'h0007, 16'h0001);
        bus.st_en   = 1'b1;
        bus.st_addr = 16'h0007;
        bus.st_data = 16'h00FF;
        bus.ld_en   = 1'b1;
        bus.ld_addr = 16'h0007;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.ld_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL bypass_early_vld: got %b expected 0", bus.ld_vld);
        end
        tick();
        n_checks++;
        if (bus.ld_vld !== 1'b1 || bus.ld_data !== 16'h00FF) begin
            n_errors++;
            $display("FAIL bypass_data: got vld=%b data=%h expected vld=1 data=00ff",
                     bus.ld_vld, bus.ld_data);
        end
    endtask

    task automatic test_late_store();
        drive_store(16'h0003, 16'h0010);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 16'h0003;
        tick();
        bus.ld_en   = 1'b0;
        bus.st_en   = 1'b1;
        bus.st_addr = 16'h0003;
        bus.st_data = 16'hBEEF;
        tick();
        bus.st_en = 1'b0;
        n_checks++;
        if (bus.ld_vld !== 1'b1 || bus.ld_data !== 16'h0010) begin
            n_errors++;
            $display("FAIL late_store_ignored: got vld=%b data=%h expected vld=1 data=0010",
                     bus.ld_vld, bus.ld_data);
        end
        bus.ld_en   = 1'b1;
        bus.ld_addr = 16'h0003;
        tick();
        bus.ld_en = 1'b0;
        tick();
        n_checks++;
        if (bus.ld_vld !== 1'b1 || bus.ld_data !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL late_store_visible: got vld=%b data=%h expected vld=1 data=beef",
                     bus.ld_vld, bus.ld_data);
        end
        tick();
        n_checks++;
        if (bus.ld_vld !== 1'b0 || bus.ld_data !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL ld_data_hold: got vld=%b data=%h expected vld=0 data=beef",
                     bus.ld_vld, bus.ld_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_data [3];
        exp_data[0] = 16'h000A;
        exp_data[1] = 16'h000A;
        exp_data[2] = 16'hBEEF;
        drive_store(16'h0002, 16'h000A);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 16'h0012;
        tick();
        bus.ld_addr = 16'h0002;
        tick();
        bus.ld_addr = 16'hFFF3;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.ld_vld !== 1'b1 || bus.ld_data !== exp_data[i]) begin
                n_errors++;
                $display("FAIL back_to_back_%0d: got vld=%b data=%h expected vld=1 data=%h",
                         i, bus.ld_vld, bus.ld_data, exp_data[i]);
            end
            tick();
            bus.ld_en = 1'b0;
        end
        n_checks++;
        if (bus.ld_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL back_to_back_drain: got vld=%b expected 0", bus.ld_vld);
        end
    endtask

    task automatic test_reset_mid();
        logic vld_seen;
        bus.ld_en   = 1'b1;
        bus.ld_addr = 16'h0005;
        tick();
        bus.ld_en = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_busy: got %b expected 1", bus.busy);
        end
        vld_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.ld_vld !== 1'b0) vld_seen = 1'b1;
            tick();
        end
        release_and_check_busy("reset_mid");
        for (int i = 0; i < 2; i++) begin
            if (bus.ld_vld !== 1'b0) vld_seen = 1'b1;
            tick();
        end
        n_checks++;
        if (vld_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_discard: got ld_vld seen=%b expected 0", vld_seen);
        end
        bus.ld_en   = 1'b1;
        bus.ld_addr = 16'h0005;
        tick();
        bus.ld_en = 1'b0;
        tick();
`ifdef TAPE_MEM_CLEAR_EN
        n_checks++;
        if (bus.ld_vld !== 1'b1 || bus.ld_data !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_mid_recleared: got vld=%b data=%h expected vld=1 data=0000",
                     bus.ld_vld, bus.ld_data);
        end
`else
        n_checks++;
        if (bus.ld_vld !== 1'b1 || bus.ld_data !== 16'h1234) begin
            n_errors++;
            $display("FAIL reset_mid_retained: got vld=%b data=%h expected vld=1 data=1234",
                     bus.ld_vld, bus.ld_data);
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_clear();
        test_store_load();
        test_bypass();
        test_late_store();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
